calculation_unit_sequencer: RTL and testbench
=============================================

Name: calculation_unit_sequencer

Overview:
- Issue and sequencing controller for the FPU calculation unit.
- Accepts one operation per cycle over a valid/ready handshake.
- Tracks ADD/SUB/MUL through the fixed-latency fraction pipeline and steps the shared iterative divide/square-root engine through load and iterate phases.
- Drives the registered fraction-select code, with result-valid and tag, aligned to the cycle the calculation fraction selecter outputs that operation's fraction.

Parameters:
- PIPE_LATENCY, 3: cycles from ADD/SUB/MUL handshake to result; legal range 1..8.
- ITERATIONS, 26: DIV/SQRT iteration cycles (one quotient/root bit each, 26-bit quotient_root).
- TAG_WIDTH, 4: width of the opaque operation tag.
- Constraint: ITERATIONS+2 > PIPE_LATENCY.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  sequencer can accept op_select this cycle.
- op_select  in  3  calc2::fraction_select code: ADD, SUB, MUL, DIV, SQRT.
- op_tag  in  TAG_WIDTH  tag returned with the result.
- flush  in  1  synchronous abort of all in-flight work.
- iter_start  out  1  iterative engine loads operands (LOAD cycle).
- iter_enable  out  1  iterative engine performs one iteration.
- iter_count  out  5  index of the current iteration, 0..ITERATIONS-1.
- busy  out  1  iterative engine occupied (state != IDLE).
- calculation_fraction_select  out  3  select code for the result cycle.
- result_valid  out  1  calculated_fraction is valid this cycle.
- result_tag  out  TAG_WIDTH  tag of the result.

Behaviour:
- Handshake occurs in a cycle with op_valid && op_ready. op_ready is combinational from op_select and internal state only; it never depends on op_valid. Undefined select codes are treated as ADD.
- Pipe ops (ADD/SUB/MUL):
  - Handshake in cycle C gives result_valid in cycle C+PIPE_LATENCY, with that op's select and tag.
  - Tracked by a PIPE_LATENCY-deep valid/select/tag shift register.
  - Full throughput of 1 per cycle.
- Iterative FSM, states IDLE, LOAD, ITERATE, FINISH:
  - IDLE -> LOAD on a DIV/SQRT handshake.
  - LOAD lasts 1 cycle with iter_start=1 and iter_count=0.
  - ITERATE lasts ITERATIONS cycles with iter_enable=1 and iter_count counting 0..ITERATIONS-1.
  - FINISH lasts 1 cycle with result_valid=1, select DIV/SQRT and stored tag; then -> IDLE.
  - DIV/SQRT handshake in cycle C gives result_valid in cycle C+ITERATIONS+2.
- Countdown cd:
  - Loaded to ITERATIONS+1 on entering LOAD; decrements each cycle; equals 0 in FINISH.
- op_ready rules:
  - DIV/SQRT: op_ready=1 only in IDLE, so a second iterative op waits. A DIV/SQRT may issue in the FINISH cycle only after returning to IDLE, i.e. the next cycle.
  - ADD/SUB/MUL: op_ready=1 except when state != IDLE and cd == PIPE_LATENCY. This blocks the single slot that would collide with FINISH, so two result_valid sources never coincide.
  - Pipe ops issued before a DIV/SQRT can never collide, by the parameter constraint.
- Output registers:
  - result_valid, calculation_fraction_select and result_tag are registered.
  - calculation_fraction_select and result_tag hold their last value when result_valid=0.
- flush (synchronous):
  - Next cycle: all pipe valids are cleared, FSM is IDLE, cd=0, result_valid=0, iter_start and iter_enable are 0.
  - A handshake in the flush cycle is discarded, and op_ready is forced to 0 during flush.
- Reset (asynchronous, any time including mid-iteration):
  - FSM IDLE, pipe valids 0, cd 0.
  - result_valid=0, iter_start=0, iter_enable=0, iter_count=0, busy=0.
  - calculation_fraction_select=ADD, result_tag=0.
  - After reset, op_ready=1 for all codes.
- iter_count holds 0 outside ITERATE; busy=1 in LOAD, ITERATE and FINISH.

Test Plan:
- Defaults: ADD tag 5 handshake at cycle 10 -> result_valid only in cycle 13, select ADD, tag 5; no other result_valid pulses.
- Back-to-back pipe ops: MUL t1, SUB t2, ADD t3 in cycles 0,1,2 -> result_valid cycles 3,4,5 with MUL/SUB/ADD and tags 1,2,3; op_ready stays 1.
- DIV timing: DIV tag 9 at cycle 0 ->
  - iter_start=1 in cycle 1 only;
  - iter_enable=1 in cycles 2..27 with iter_count 0..25;
  - result_valid in cycle 28 with DIV, tag 9;
  - busy=0 from cycle 29.
- Collision slot and busy rejection: SQRT at cycle 0, then ADD held valid every cycle ->
  - op_ready=0 for ADD in cycle 25 only;
  - ADD results in every cycle 4..31 except cycle 28, which carries SQRT;
  - a DIV request during cycles 1..28 sees op_ready=0.
- Abort:
  - reset_n low in cycle 15 of a DIV -> all outputs take reset values immediately, with no later result_valid.
  - flush in cycle 15 of a DIV, with MUL in flight -> no result_valid afterwards; busy=0 from cycle 16.
  - A fresh DIV accepted at cycle 17 completes in cycle 45.

Source files
------------

// File: rtl/calculation_unit_sequencer.sv
// rtl/calculation_unit_sequencer.sv - issue and sequencing controller for the FPU calculation unit
//
// Purpose:
//   Accepts one operation per cycle over op_valid/op_ready. ADD/SUB/MUL are
//   tracked through the fixed-latency fraction pipeline. DIV/SQRT step the
//   shared iterative engine through LOAD, ITERATE and FINISH. The registered
//   fraction-select code, result_valid and result_tag line up with the cycle
//   in which the fraction selecter presents that operation's fraction.
//
// Ports:
//   clk                         in   rising-edge clock
//   reset_n                     in   asynchronous active-low reset
//   op_valid / op_ready         in/out  operation handshake
//   op_select                   in   fraction-select code (ADD/SUB/MUL/DIV/SQRT)
//   op_tag                      in   opaque tag returned with the result
//   flush                       in   synchronous abort of all in-flight work
//   iter_start                  out  iterative engine loads operands
//   iter_enable                 out  iterative engine performs one iteration
//   iter_count                  out  current iteration index
//   busy                        out  iterative engine occupied
//   calculation_fraction_select out  select code for the result cycle
//   result_valid                out  calculated fraction valid this cycle
//   result_tag                  out  tag of the result

module calculation_unit_sequencer #(
    parameter int PIPE_LATENCY = 3,
    parameter int ITERATIONS   = 26,
    parameter int TAG_WIDTH    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [2:0]           op_select,
    input  logic [TAG_WIDTH-1:0] op_tag,
    input  logic                 flush,
    output logic                 iter_start,
    output logic                 iter_enable,
    output logic [4:0]           iter_count,
    output logic                 busy,
    output logic [2:0]           calculation_fraction_select,
    output logic                 result_valid,
    output logic [TAG_WIDTH-1:0] result_tag
);

    localparam logic [2:0] SEL_ADD  = 3'd0;
    localparam logic [2:0] SEL_SUB  = 3'd1;
    localparam logic [2:0] SEL_MUL  = 3'd2;
    localparam logic [2:0] SEL_DIV  = 3'd3;
    localparam logic [2:0] SEL_SQRT = 3'd4;

    localparam int CD_W = $clog2(ITERATIONS + 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_ITERATE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CD_W-1:0]        r_cd;
    logic [2:0]             r_iter_sel;
    logic [TAG_WIDTH-1:0]   r_iter_tag;
    logic                   r_iter_start;
    logic                   r_iter_enable;
    logic [4:0]             r_iter_count;
    logic                   r_result_valid;
    logic [2:0]             r_result_sel;
    logic [TAG_WIDTH-1:0]   r_result_tag;

    logic                   w_is_iter;
    logic [2:0]             w_norm_sel;
    logic                   w_cd_block;
    logic                   w_hs;
    logic                   w_hs_iter;
    logic                   w_hs_pipe;
    logic                   w_to_finish;
    logic                   w_tail_valid;
    logic [2:0]             w_tail_sel;
    logic [TAG_WIDTH-1:0]   w_tail_tag;

    // Codes outside the five defined ones behave exactly like ADD.
    always_comb begin
        w_norm_sel = SEL_ADD;
        case (op_select)
            SEL_SUB:  w_norm_sel = SEL_SUB;
            SEL_MUL:  w_norm_sel = SEL_MUL;
            SEL_DIV:  w_norm_sel = SEL_DIV;
            SEL_SQRT: w_norm_sel = SEL_SQRT;
            default:  w_norm_sel = SEL_ADD;
        endcase
    end

    assign w_is_iter = (w_norm_sel == SEL_DIV) || (w_norm_sel == SEL_SQRT);

    // A pipe op accepted while cd equals the pipe latency would emerge in the
    // FINISH cycle; refusing exactly that slot keeps the two result sources apart.
    assign w_cd_block = (r_state != S_IDLE) && (r_cd == CD_W'(PIPE_LATENCY));

    assign op_ready  = !flush && (w_is_iter ? (r_state == S_IDLE) : !w_cd_block);
    assign w_hs      = op_valid && op_ready;
    assign w_hs_iter = w_hs && w_is_iter;
    assign w_hs_pipe = w_hs && !w_is_iter;

    // Last ITERATE cycle: the next cycle is FINISH and carries the result.
    assign w_to_finish = (r_state == S_ITERATE) && (r_cd == CD_W'(1));

    // The output register is the final stage of the pipe tracker, so only
    // PIPE_LATENCY-1 internal stages are needed in front of it.
    generate
        if (PIPE_LATENCY == 1) begin : g_direct
            assign w_tail_valid = w_hs_pipe;
            assign w_tail_sel   = w_norm_sel;
            assign w_tail_tag   = op_tag;
        end else begin : g_pipe
            logic [PIPE_LATENCY-2:0] r_pv;
            logic [2:0]              r_ps [PIPE_LATENCY-1];
            logic [TAG_WIDTH-1:0]    r_pt [PIPE_LATENCY-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < PIPE_LATENCY - 1; i++) begin
                        r_pv[i] <= 1'b0;
                        r_ps[i] <= SEL_ADD;
                        r_pt[i] <= '0;
                    end
                end else begin
                    r_pv[0] <= w_hs_pipe && !flush;
                    r_ps[0] <= w_norm_sel;
                    r_pt[0] <= op_tag;
                    for (int i = 1; i < PIPE_LATENCY - 1; i++) begin
                        r_pv[i] <= r_pv[i-1] && !flush;
                        r_ps[i] <= r_ps[i-1];
                        r_pt[i] <= r_pt[i-1];
                    end
                end
            end

            assign w_tail_valid = r_pv[PIPE_LATENCY-2];
            assign w_tail_sel   = r_ps[PIPE_LATENCY-2];
            assign w_tail_tag   = r_pt[PIPE_LATENCY-2];
        end
    endgenerate

    // Iterative FSM with registered engine controls and result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_cd           <= '0;
            r_iter_sel     <= SEL_DIV;
            r_iter_tag     <= '0;
            r_iter_start   <= 1'b0;
            r_iter_enable  <= 1'b0;
            r_iter_count   <= 5'd0;
            r_result_valid <= 1'b0;
            r_result_sel   <= SEL_ADD;
            r_result_tag   <= '0;
        end else if (flush) begin
            r_state        <= S_IDLE;
            r_cd           <= '0;
            r_iter_start   <= 1'b0;
            r_iter_enable  <= 1'b0;
            r_iter_count   <= 5'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_to_finish || w_tail_valid;
            if (w_to_finish) begin
                r_result_sel <= r_iter_sel;
                r_result_tag <= r_iter_tag;
            end else if (w_tail_valid) begin
                r_result_sel <= w_tail_sel;
                r_result_tag <= w_tail_tag;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_hs_iter) begin
                        r_state      <= S_LOAD;
                        r_cd         <= CD_W'(ITERATIONS + 1);
                        r_iter_sel   <= w_norm_sel;
                        r_iter_tag   <= op_tag;
                        r_iter_start <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state       <= S_ITERATE;
                    r_cd          <= r_cd - CD_W'(1);
                    r_iter_start  <= 1'b0;
                    r_iter_enable <= 1'b1;
                    r_iter_count  <= 5'd0;
                end
                S_ITERATE: begin
                    r_cd <= r_cd - CD_W'(1);
                    if (w_to_finish) begin
                        r_state       <= S_FINISH;
                        r_iter_enable <= 1'b0;
                        r_iter_count  <= 5'd0;
                    end else begin
                        r_iter_count  <= r_iter_count + 5'd1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign iter_start                  = r_iter_start;
    assign iter_enable                 = r_iter_enable;
    assign iter_count                  = r_iter_count;
    assign busy                        = (r_state != S_IDLE);
    assign calculation_fraction_select = r_result_sel;
    assign result_valid                = r_result_valid;
    assign result_tag                  = r_result_tag;

endmodule

// File: tb/tb_calculation_unit_sequencer.sv
// tb/tb_calculation_unit_sequencer.sv - scoreboard bench for calculation_unit_sequencer

module tb_calculation_unit_sequencer;

    localparam int PIPE_LAT = 3;
    localparam int ITERS    = 26;
    localparam int ITER_LAT = ITERS + 2;

    localparam logic [2:0] ADD  = 3'd0;
    localparam logic [2:0] SUB  = 3'd1;
    localparam logic [2:0] MUL  = 3'd2;
    localparam logic [2:0] DIV  = 3'd3;
    localparam logic [2:0] SQRT = 3'd4;

    logic       clk;
    logic       reset_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_select;
    logic [3:0] op_tag;
    logic       flush;
    logic       iter_start;
    logic       iter_enable;
    logic [4:0] iter_count;
    logic       busy;
    logic [2:0] calculation_fraction_select;
    logic       result_valid;
    logic [3:0] result_tag;

    calculation_unit_sequencer #(
        .PIPE_LATENCY (PIPE_LAT),
        .ITERATIONS   (ITERS),
        .TAG_WIDTH    (4)
    ) dut (
        .clk                         (clk),
        .reset_n                     (reset_n),
        .op_valid                    (op_valid),
        .op_ready                    (op_ready),
        .op_select                   (op_select),
        .op_tag                      (op_tag),
        .flush                       (flush),
        .iter_start                  (iter_start),
        .iter_enable                 (iter_enable),
        .iter_count                  (iter_count),
        .busy                        (busy),
        .calculation_fraction_select (calculation_fraction_select),
        .result_valid                (result_valid),
        .result_tag                  (result_tag)
    );

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic [3:0] tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Drives one request for a cycle, checks op_ready against exp_ready and,
    // if accepted, records the result expected from the bench's timing model.
    task automatic issue(input logic [2:0] sel, input logic [3:0] tag, input logic exp_ready);
        exp_t e;
        logic [2:0] esel;
        esel = (sel > SQRT) ? ADD : sel;
        op_valid  = 1'b1;
        op_select = sel;
        op_tag    = tag;
        @(negedge clk);
        chk("issue_ready", op_ready, exp_ready);
        if (op_ready) begin
            e.cyc = cyc + (((esel == DIV) || (esel == SQRT)) ? ITER_LAT : PIPE_LAT);
            e.sel = esel;
            e.tag = tag;
            sb.push_back(e);
        end
        tick();
        op_valid = 1'b0;
    endtask

    // Scoreboard: every result_valid pulse must match an expectation due now.
    always @(negedge clk) begin
        int idx;
        idx = -1;
        if (reset_n && result_valid) begin
            foreach (sb[i]) if (sb[i].cyc == cyc) idx = i;
            if (idx < 0) begin
                chk("spurious_result", 32'd1, 32'd0);
            end else begin
                chk("res_sel", calculation_fraction_select, sb[idx].sel);
                chk("res_tag", result_tag, sb[idx].tag);
                sb.delete(idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        op_valid  = 1'b0;
        op_select = ADD;
        op_tag    = 4'd0;
        flush     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_iter_start", iter_start, 0);
        chk("rst_iter_enable", iter_enable, 0);
        chk("rst_iter_count", iter_count, 0);
        chk("rst_sel", calculation_fraction_select, ADD);
        chk("rst_tag", result_tag, 0);
        reset_n = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            op_select = 3'(c);
            #1;
            chk("rst_ready_all_codes", op_ready, 1);
        end

        // Single ADD: result exactly PIPE_LAT cycles later
        tick();
        base = cyc;
        run_to(base + 10);
        issue(ADD, 4'd5, 1'b1);
        run_to(base + 20);
        chk("add_drained", sb.size(), 0);

        // Back-to-back pipe ops, including an undefined code treated as ADD
        issue(MUL, 4'd1, 1'b1);
        issue(SUB, 4'd2, 1'b1);
        issue(ADD, 4'd3, 1'b1);
        issue(3'd7, 4'd6, 1'b1);
        run_to(cyc + 6);
        chk("b2b_drained", sb.size(), 0);

        // DIV timing of engine controls
        base = cyc;
        issue(DIV, 4'd9, 1'b1);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            chk("div_iter_start", iter_start, (k == 1));
            chk("div_iter_enable", iter_enable, (k >= 2 && k <= 27));
            chk("div_iter_count", iter_count, (k >= 2 && k <= 27) ? (k - 2) : 0);
            chk("div_busy", busy, (k <= 28));
            tick();
        end
        chk("div_drained", sb.size(), 0);

        // SQRT with ADD held valid every cycle: one collision slot is refused
        base = cyc;
        issue(SQRT, 4'd10, 1'b1);
        for (int k = 1; k <= 28; k++) begin
            op_valid  = 1'b1;
            op_select = DIV;
            op_tag    = 4'(k);
            @(negedge clk);
            chk("busy_div_ready", op_ready, 0);
            op_select = ADD;
            #1;
            chk("slot_add_ready", op_ready, (k != 25));
            if (op_ready) sb.push_back('{cyc + PIPE_LAT, ADD, 4'(k)});
            tick();
        end
        op_valid  = 1'b0;
        op_select = DIV;
        @(negedge clk);
        chk("idle_div_ready", op_ready, 1);
        run_to(base + 36);
        chk("sqrt_drained", sb.size(), 0);

        // Reset in the middle of a DIV
        base = cyc;
        issue(DIV, 4'd3, 1'b1);
        run_to(base + 15);
        reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_iter_enable", iter_enable, 0);
        chk("arst_iter_count", iter_count, 0);
        chk("arst_result_valid", result_valid, 0);
        chk("arst_sel", calculation_fraction_select, ADD);
        chk("arst_tag", result_tag, 0);
        sb.delete();
        tick();
        tick();
        reset_n = 1'b1;
        run_to(base + 35);
        chk("arst_no_result", sb.size(), 0);

        // Flush in the middle of a DIV with a MUL in flight
        base = cyc;
        issue(DIV, 4'd11, 1'b1);
        run_to(base + 13);
        issue(MUL, 4'd12, 1'b1);
        run_to(base + 15);
        flush     = 1'b1;
        op_valid  = 1'b1;
        op_select = ADD;
        op_tag    = 4'd14;
        @(negedge clk);
        chk("flush_ready", op_ready, 0);
        tick();
        flush    = 1'b0;
        op_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_result_valid", result_valid, 0);
        chk("flush_iter_enable", iter_enable, 0);
        chk("flush_iter_start", iter_start, 0);
        run_to(base + 17);
        issue(DIV, 4'd13, 1'b1);
        run_to(base + 44);
        @(negedge clk);
        chk("fresh_div_pending", sb.size(), 1);
        run_to(base + 48);
        chk("fresh_div_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
